redmule_qint_pack: RTL

Stream packer that narrows 8-bit-per-lane integer data into dense QINT_4 or QINT_2 words. For QINT_8 the data passes through unchanged. It is the write-side counterpart of the low-bit-int unpack/zero-extend cast, and sits between the engine's quantised result stream and the store streamer. R input beats are accumulated into one full DW-bit output word. A flush request emits a partially filled word.

---
 rtl/redmule_qint_pack_if.sv | 23 ++
 rtl/redmule_qint_pack.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/redmule_qint_pack_if.sv
// Target-format enum and the valid/ready stream interface (with byte strobe)
// used on both sides of the low-bit integer packer.
package redmule_qint_pkg;
    typedef enum logic [1:0] {
        QINT_8 = 2'd0,
        QINT_4 = 2'd1,
        QINT_2 = 2'd2
    } qint_fmt_e;
endpackage

interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/redmule_qint_pack.sv
// Packs 8-bit-per-lane integer beats into dense QINT_4 / QINT_2 words
// (QINT_8 passes through); a flush emits a partially filled word.
module redmule_qint_pack
    import redmule_qint_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  qint_fmt_e                     fmt_i,
    input  logic                          flush_i,
    hwpe_stream_intf_stream.sink          stream_i,
    hwpe_stream_intf_stream.source        stream_o,
    output logic                          idle_o
);
    localparam int unsigned LANES  = DW / 8;
    localparam int unsigned SW     = DW / 8;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned FILL_W = $clog2(SW + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic [SW-1:0]     out_strb_q, out_strb_d;
    logic              out_valid_q, out_valid_d;
    logic              flush_pend_q, flush_pend_d;
    logic              idle_q, idle_d;

    logic [DW/2-1:0]   beat4_c;
    logic [DW/4-1:0]   beat2_c;
    logic [DW-1:0]     beat_shift_c;
    logic [CNT_W-1:0]  last_cnt_c;
    logic [CNT_W-1:0]  cnt_after_c;
    logic [DW-1:0]     acc_after_c;
    logic [FILL_W-1:0] filled_c;
    logic [SW-1:0]     part_strb_c;
    logic              out_busy_c;
    logic              accept_c;
    logic              complete_c;
    logic              flush_req_c;
    logic              unused_strb_c;

    // Input strobes carry no meaning for packing.
    assign unused_strb_c = ^stream_i.strb;

    // Low b bits of every lane, densely concatenated (plain truncation).
    always_comb begin
        beat4_c = '0;
        beat2_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            beat4_c[i*4 +: 4] = stream_i.data[i*8 +: 4];
            beat2_c[i*2 +: 2] = stream_i.data[i*8 +: 2];
        end
    end

    // Slot placement of the current beat and last beat index per format.
    always_comb begin
        case (fmt_i)
            QINT_4: begin
                last_cnt_c   = CNT_W'(1);
                beat_shift_c = DW'(beat4_c) << (32'(cnt_q) * (DW / 2));
            end
            QINT_2: begin
                last_cnt_c   = CNT_W'(3);
                beat_shift_c = DW'(beat2_c) << (32'(cnt_q) * (DW / 4));
            end
            default: begin
                last_cnt_c   = CNT_W'(0);
                beat_shift_c = stream_i.data;
            end
        endcase
    end

    assign out_busy_c     = out_valid_q && !stream_o.ready;
    assign stream_i.ready = !flush_pend_q && !((cnt_q == last_cnt_c) && out_busy_c);

    always_comb begin
        accept_c    = stream_i.valid && stream_i.ready;
        complete_c  = accept_c && (cnt_q == last_cnt_c);
        cnt_after_c = accept_c ? cnt_q + CNT_W'(1) : cnt_q;
        acc_after_c = accept_c ? (acc_q | beat_shift_c) : acc_q;
        flush_req_c = flush_i || flush_pend_q;
    end

    // Byte strobe of a partial word: bytes covered by the accepted beats.
    always_comb begin
        case (fmt_i)
            QINT_4:  filled_c = FILL_W'(32'(cnt_after_c) * (SW / 2));
            QINT_2:  filled_c = FILL_W'(32'(cnt_after_c) * (SW / 4));
            default: filled_c = FILL_W'(SW);
        endcase
        part_strb_c = '0;
        for (int unsigned i = 0; i < SW; i++) begin
            part_strb_c[i] = (FILL_W'(i) < filled_c);
        end
    end

    always_comb begin
        cnt_d        = cnt_after_c;
        acc_d        = acc_after_c;
        out_data_d   = out_data_q;
        out_strb_d   = out_strb_q;
        out_valid_d  = out_valid_q && !stream_o.ready;
        flush_pend_d = 1'b0;
        if (complete_c) begin
            cnt_d       = '0;
            acc_d       = '0;
            out_data_d  = acc_after_c;
            out_strb_d  = '1;
            out_valid_d = 1'b1;
        end else if (flush_req_c && (cnt_after_c != '0)) begin
            if (out_busy_c) begin
                flush_pend_d = 1'b1;
            end else begin
                cnt_d       = '0;
                acc_d       = '0;
                out_data_d  = acc_after_c;
                out_strb_d  = part_strb_c;
                out_valid_d = 1'b1;
            end
        end
        if (clear_i) begin
            cnt_d        = '0;
            acc_d        = '0;
            out_valid_d  = 1'b0;
            flush_pend_d = 1'b0;
        end
        idle_d = (cnt_d == '0) && !out_valid_d && !flush_pend_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
            out_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            out_strb_q   <= out_strb_d;
            out_valid_q  <= out_valid_d;
            flush_pend_q <= flush_pend_d;
            idle_q       <= idle_d;
        end
    end

    assign stream_o.valid = out_valid_q;
    assign stream_o.data  = out_data_q;
    assign stream_o.strb  = out_strb_q;
    assign idle_o         = idle_q;

endmodule
